// File: rtl/and_gate_bist.sv
`default_nettype none
// ============================================================================
//  Module      : and_gate_bist
//  Description : Built-in self-test sequencer for a 2-input AND gate. Walks
//                the gate inputs through 00, 01, 10, 11, holds each vector
//                for SETTLE_CYCLES cycles, samples the gate output, counts
//                mismatches and reports pass/fail with the first failing
//                vector.
//  Options     : AND_BIST_STOP_ON_FAIL_EN - when defined, the first
//                mismatching vector ends the run immediately.
//  Revision    : 1.0 - initial release
// ============================================================================
module and_gate_bist #(
    parameter int SETTLE_CYCLES = 2      // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    output logic       gate_a_o,
    output logic       gate_b_o,
    input  logic       gate_y_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [2:0] err_count_o,
    output logic [1:0] fail_vec_o
);

    // Settle counter is wide enough for the largest legal settle time.
    localparam int         CNT_W         = 4;
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0] C_LAST_VEC    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [1:0]       vec_q,      vec_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             gate_a_q,   gate_a_d;
    logic             gate_b_q,   gate_b_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             pass_q,     pass_d;
    logic [2:0]       err_q,      err_d;
    logic [1:0]       fail_vec_q, fail_vec_d;

    // Gate output disagrees with the AND of the vector currently applied.
    logic             mismatch;
    // CHECK of the current vector ends the run.
    logic             end_run;

    assign mismatch = (gate_y_i != (vec_q[1] & vec_q[0]));

`ifdef AND_BIST_STOP_ON_FAIL_EN
    assign end_run = mismatch || (vec_q == C_LAST_VEC);
`else
    assign end_run = (vec_q == C_LAST_VEC);
`endif

    // State register and all registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec_q      <= 2'd0;
            cnt_q      <= '0;
            gate_a_q   <= 1'b0;
            gate_b_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 3'd0;
            fail_vec_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            gate_a_q   <= gate_a_d;
            gate_b_q   <= gate_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        gate_a_d   = gate_a_q;
        gate_b_d   = gate_b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        fail_vec_d = fail_vec_q;

        case (state_q)
            S_IDLE: begin
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
                if (start_i) begin
                    // Results of the previous run are discarded only here.
                    err_d      = 3'd0;
                    fail_vec_d = 2'd0;
                    pass_d     = 1'b0;
                    vec_d      = 2'd0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt_q == C_SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 3'd1;
                    // A zero count means this is the first failing vector.
                    if (err_q == 3'd0) begin
                        fail_vec_d = vec_q;
                    end
                end
                if (end_run) begin
                    // Pass uses the updated count so the last vector counts.
                    pass_d   = (err_d == 3'd0);
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    vec_d    = vec_q + 2'd1;
                    gate_a_d = vec_d[1];
                    gate_b_d = vec_d[0];
                    state_d  = S_SETTLE;
                end
            end

            S_DONE: begin
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gate_a_o    = gate_a_q;
    assign gate_b_o    = gate_b_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_vec_o  = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_and_gate_bist.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_and_gate_bist
//  Description : Self-checking bench for and_gate_bist. A cycle-indexed model
//                predicts every output each cycle; directed runs add literal
//                expectations taken from hand-worked timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_and_gate_bist;

    localparam int S = 2;
`ifdef AND_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // Gate models hooked to the DUT.
    localparam int M_AND = 0;
    localparam int M_SA0 = 1;
    localparam int M_SA1 = 2;
    localparam int M_OR  = 3;

    // Literal expectation field selectors.
    localparam int F_DONE  = 0;
    localparam int F_PASS  = 1;
    localparam int F_ERR   = 2;
    localparam int F_FVEC  = 3;
    localparam int F_BUSY  = 4;
    localparam int F_NDONE = 5;
    localparam int F_GATES = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       gate_y;
    logic       ga, gb, busy, done, pass;
    logic [2:0] errc;
    logic [1:0] fv;
    int         mode = M_AND;

    and_gate_bist #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .gate_a_o   (ga),
        .gate_b_o   (gb),
        .gate_y_i   (gate_y),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .err_count_o(errc),
        .fail_vec_o (fv)
    );

    always #5 clk = ~clk;

    // Gate under test, selectable fault model.
    always_comb begin
        case (mode)
            M_AND:   gate_y = ga & gb;
            M_SA0:   gate_y = 1'b0;
            M_SA1:   gate_y = 1'b1;
            default: gate_y = ga | gb;
        endcase
    end

    // ------------------------------------------------------------------
    // Specification-level model: everything derived from the run start
    // cycle and the gate model used for that run.
    // ------------------------------------------------------------------
    function automatic bit y_of(int m, int k);
        bit a, b;
        a = ((k >> 1) & 1) != 0;
        b = (k & 1) != 0;
        case (m)
            M_AND:   return a & b;
            M_SA0:   return 1'b0;
            M_SA1:   return 1'b1;
            default: return a | b;
        endcase
    endfunction

    function automatic bit mism(int m, int k);
        return y_of(m, k) != (k == 3);
    endfunction

    // Index of first failing vector, 4 if none.
    function automatic int first_fail(int m);
        for (int k = 0; k < 4; k++) if (mism(m, k)) return k;
        return 4;
    endfunction

    function automatic int last_vec(int m);
        if (STOP && first_fail(m) < 4) return first_fail(m);
        return 3;
    endfunction

    function automatic int done_at(int m);
        return (last_vec(m) + 1) * (S + 1) + 1;
    endfunction

    int edge_idx = 0;
    int s0 = 0;
    int run_mode = M_AND;
    bit has_run = 1'b0;
    bit chk_en = 1'b0;

    // Tracks which start requests the block must honour.
    always @(posedge clk) begin
        if (rst) begin
            has_run <= 1'b0;
            chk_en  <= 1'b1;
        end else if (start && (!has_run || (edge_idx - s0) >= done_at(run_mode) + 1)) begin
            has_run  <= 1'b1;
            s0       <= edge_idx;
            run_mode <= mode;
        end
        edge_idx <= edge_idx + 1;
    end

    // Predicted {a,b,busy,done,pass,err_count,fail_vec} for the current cycle.
    function automatic logic [9:0] model_out();
        int r, d, e, f;
        logic [1:0] g;
        logic bz, dn, ps;
        if (!has_run) return '0;
        r  = edge_idx - s0;
        d  = done_at(run_mode);
        bz = (r >= 1) && (r < d);
        dn = (r == d);
        g  = 2'b00;
        if (bz) g = 2'((r - 1) / (S + 1));
        e = 0;
        f = -1;
        for (int k = 0; k <= last_vec(run_mode); k++) begin
            if ((k + 1) * (S + 1) < r && mism(run_mode, k)) begin
                e++;
                if (f < 0) f = k;
            end
        end
        ps = (r >= d) && (first_fail(run_mode) == 4);
        return {g, bz, dn, ps, 3'(e), (f < 0) ? 2'b00 : 2'(f)};
    endfunction

    typedef struct {
        int cyc;
        int fld;
        int val;
    } lit_t;
    lit_t lit_q[$];

    task automatic expect_at(input int c, input int f, input int v);
        lit_t l;
        l.cyc = c;
        l.fld = f;
        l.val = v;
        lit_q.push_back(l);
    endtask

    function automatic string fname(int f);
        case (f)
            F_DONE:  return "done";
            F_PASS:  return "pass";
            F_ERR:   return "err_count";
            F_FVEC:  return "fail_vec";
            F_BUSY:  return "busy";
            F_NDONE: return "done_pulses";
            default: return "gates";
        endcase
    endfunction

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;

    function automatic int field(int f);
        case (f)
            F_DONE:  return int'(done);
            F_PASS:  return int'(pass);
            F_ERR:   return int'(errc);
            F_FVEC:  return int'(fv);
            F_BUSY:  return int'(busy);
            F_NDONE: return done_cnt;
            default: return int'({ga, gb});
        endcase
    endfunction

    // Single compare point: model check every cycle plus pinned literals.
    always @(negedge clk) begin
        logic [9:0] exp_v, act_v;
        int got;
        if (chk_en) begin
            exp_v = model_out();
            act_v = {ga, gb, busy, done, pass, errc, fv};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model cycle %0d {a,b,busy,done,pass,err_count,fail_vec}: got %b expected %b",
                         edge_idx, act_v, exp_v);
            end
            if (done === 1'b1) done_cnt++;
            foreach (lit_q[i]) begin
                if (lit_q[i].cyc == edge_idx) begin
                    n_cmp++;
                    got = field(lit_q[i].fld);
                    if (got != lit_q[i].val) begin
                        n_fail++;
                        $display("FAIL literal %s at cycle %0d: got %0d expected %0d",
                                 fname(lit_q[i].fld), edge_idx, got, lit_q[i].val);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses start for one edge and returns the index of that edge.
    task automatic pulse_start(output int st);
        start = 1'b1;
        step(1);
        st = edge_idx - 1;
        start = 1'b0;
    endtask

    int st;
    int n_done_exp;

    initial begin
        n_done_exp = 0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        expect_at(edge_idx + 1, F_BUSY, 0);
        expect_at(edge_idx + 1, F_ERR, 0);
        step(2);

        // Good AND gate: full walk, pass.
        mode = M_AND;
        pulse_start(st);
        expect_at(st + 1,  F_BUSY, 1);
        expect_at(st + 1,  F_GATES, 0);
        expect_at(st + 4,  F_GATES, 1);
        expect_at(st + 7,  F_GATES, 2);
        expect_at(st + 10, F_GATES, 3);
        expect_at(st + 12, F_BUSY, 1);
        expect_at(st + 12, F_DONE, 0);
        expect_at(st + 13, F_DONE, 1);
        expect_at(st + 13, F_BUSY, 0);
        expect_at(st + 13, F_GATES, 0);
        expect_at(st + 13, F_PASS, 1);
        expect_at(st + 13, F_ERR, 0);
        expect_at(st + 13, F_FVEC, 0);
        n_done_exp++;
        step(16);

        // Stuck-at-0: only the 11 vector fails.
        mode = M_SA0;
        pulse_start(st);
        expect_at(st + 13, F_DONE, 1);
        expect_at(st + 13, F_PASS, 0);
        expect_at(st + 13, F_ERR, 1);
        expect_at(st + 13, F_FVEC, 3);
        n_done_exp++;
        step(16);

        // Stuck-at-1: vectors 00, 01, 10 fail.
        mode = M_SA1;
        pulse_start(st);
        if (STOP) begin
            expect_at(st + 4, F_DONE, 1);
            expect_at(st + 4, F_ERR, 1);
            expect_at(st + 4, F_FVEC, 0);
        end else begin
            expect_at(st + 13, F_DONE, 1);
            expect_at(st + 13, F_ERR, 3);
            expect_at(st + 13, F_FVEC, 0);
        end
        n_done_exp++;
        step(16);

        // OR gate substituted: vectors 01 and 10 fail.
        mode = M_OR;
        pulse_start(st);
        if (STOP) begin
            expect_at(st + 7, F_DONE, 1);
            expect_at(st + 7, F_ERR, 1);
        end else begin
            expect_at(st + 13, F_DONE, 1);
            expect_at(st + 13, F_ERR, 2);
        end
        expect_at(st + 14, F_PASS, 0);
        expect_at(st + 14, F_FVEC, 1);
        n_done_exp++;
        step(16);

        // Start re-pulsed at cycles 5 and 13 must be ignored.
        mode = M_AND;
        pulse_start(st);
        step(4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        start = 1'b1;
        step(1);
        start = 1'b0;
        n_done_exp++;
        expect_at(st + 13, F_DONE, 1);
        expect_at(st + 20, F_NDONE, n_done_exp);
        step(10);

        // Reset mid-run at cycle 6, restart at cycle 8.
        pulse_start(st);
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_at(st + 7, F_BUSY, 0);
        expect_at(st + 7, F_ERR, 0);
        expect_at(st + 7, F_GATES, 0);
        step(1);
        pulse_start(st);
        expect_at(st + 13, F_DONE, 1);
        expect_at(st + 13, F_PASS, 1);
        n_done_exp++;
        step(16);

        // Start held high re-triggers on the first IDLE cycle after DONE.
        start = 1'b1;
        step(1);
        st = edge_idx - 1;
        step(29);
        start = 1'b0;
        expect_at(st + 13, F_DONE, 1);
        expect_at(st + 14, F_DONE, 0);
        expect_at(st + 15, F_BUSY, 1);
        expect_at(st + 27, F_DONE, 1);
        n_done_exp += 3;
        expect_at(st + 45, F_NDONE, n_done_exp);
        step(18);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/and_gate_bist.md
# and_gate_bist

Built-in self-test sequencer for the 2-input `and_gate` datapath block. On a start request it drives the gate's `a`/`b` inputs through all four input vectors in order 00, 01, 10, 11. After a programmable settle time it samples `y`, compares it against `a & b`, counts mismatches and reports pass/fail. It sits between a top-level test controller (`start`/`done`) and one `and_gate` instance, which it owns exclusively while busy.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before `y` is sampled; legal range 1..15.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a test run; honoured only in IDLE.
- `gate_a`  out  1  registered drive to gate input `a`.
- `gate_b`  out  1  registered drive to gate input `b`.
- `gate_y`  in  1  gate output under test.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  one-cycle pulse marking end of run.
- `pass`  out  1  result of the last run; held until the next accepted `start`.
- `err_count`  out  3  number of mismatching vectors in the last run, 0..4.
- `fail_vec`  out  2  `{a,b}` of the first mismatching vector; 0 if none.

## Operation
- Reset values: `gate_a`, `gate_b`, `busy`, `done`, `pass`, `err_count` and `fail_vec` are all 0; state is IDLE; vector index `vec` is 0; settle counter is 0.
- States:
  - IDLE: gates driven 0. `start`=1 clears `err_count`, `fail_vec` and `pass`, sets `vec`=0, gates={0,0}, `busy`=1, and moves to SETTLE.
  - SETTLE: counter increments each cycle. When the count reaches `SETTLE_CYCLES`-1, the counter clears and the state moves to CHECK.
  - CHECK: compares `gate_y` with `vec[1]&vec[0]`.
    - On mismatch, `err_count`+1. If this is the first mismatch, `fail_vec`<=`vec`.
    - If `vec`==3, move to DONE.
    - Otherwise `vec`+1, gates<=new `vec`, and return to SETTLE.
  - DONE: `done`=1 and `busy`=0. `pass` is set to 1 only if the final `err_count` is 0. Gates driven 0. Move to IDLE on the next cycle.
- `start` asserted in SETTLE, CHECK or DONE is ignored, not queued.
- A `start` held high continuously re-triggers on the first IDLE cycle after DONE.
- The mismatch decision in CHECK uses the value of `gate_y` sampled that cycle, so the result in DONE includes the last vector.
- `err_count` cannot exceed 4; no saturation logic is required.
- Reset mid-run has priority over everything: the block returns to IDLE on the same edge, and all outputs read reset values the next cycle. The partial result is discarded.

## Timing
- Per vector: `SETTLE_CYCLES` cycles in SETTLE plus 1 cycle in CHECK.
- Counting the edge that samples `start` as cycle 0, CHECK for vector k occurs in cycle (k+1)(`SETTLE_CYCLES`+1).
- `done` is high in cycle 4(`SETTLE_CYCLES`+1)+1. For the default `SETTLE_CYCLES`=2, this is cycle 13.
- `gate_a`/`gate_b` change only on transitions into SETTLE, DONE or IDLE. They are glitch-free registered outputs.
- `pass`, `err_count` and `fail_vec` are stable from the DONE cycle until the next accepted `start`.
- Minimum start-to-start spacing is 4(`SETTLE_CYCLES`+1)+2 cycles.

## Configuration
- `AND_BIST_STOP_ON_FAIL_EN` defined:
  - The first mismatch in CHECK moves the block directly to DONE, skipping the remaining vectors.
  - `err_count` is 1 and `fail_vec` is the failing vector.
  - `done` occurs at cycle (k+1)(`SETTLE_CYCLES`+1)+1, where k is the failing vector index.
- `AND_BIST_STOP_ON_FAIL_EN` undefined: all four vectors always run, and `err_count` reports the total number of mismatches.

## Test plan
- Correct AND model, `SETTLE_CYCLES`=2, `start` pulsed at cycle 0 -> gates step 00,01,10,11; `done` at cycle 13; `pass`=1, `err_count`=0, `fail_vec`=00.
- `gate_y` stuck at 0 -> `pass`=0, `err_count`=1, `fail_vec`=2'b11, `done` at cycle 13.
- `gate_y` stuck at 1, macro undefined -> `err_count`=3, `fail_vec`=2'b00, `done` at cycle 13. Same fault with macro defined -> `done` at cycle 4, `err_count`=1, `fail_vec`=2'b00.
- `start` re-pulsed at cycles 5 and 13 -> both ignored; only one `done` pulse occurs, at cycle 13; `busy` stays 1 over cycles 1..12.
- `rst` asserted at cycle 6 of a run -> cycle 7 shows all outputs 0 and `busy`=0. A new `start` at cycle 8 gives `done` at cycle 21 with correct results.
- OR-gate model substituted for the DUT gate -> `err_count`=2, `fail_vec`=2'b01, `pass`=0.
